default_chan_block_tx_sched: RTL and testbench
==============================================

// Module: default_chan_block_tx_sched
// PURPOSE
// Timed-burst TX sequencer in front of the DAC hold stage. Takes burst commands {time, length, timed}
// plus a raw 64-bit sample stream and emits the tagged stream the hold stage consumes:
// HOLD tag (carrying the start time), SOB tag, the payload words, then the EOB tag.
// Timed commands are late-checked against the live sample index; late bursts are dropped or sent untimed.
// PARAMETERS
// LEN_W       16   width of cmd_len (payload words per burst)
// LATE_MARGIN 64   minimum samples of lead time for a timed burst to be on time
// DROP_LATE   1    1: drain and discard a late burst's payload; 0: send it untimed (no HOLD tag)
// PORTS
// clk            in   1      clock
// resetn         in   1      synchronous active-low reset
// sample_idx     in   56     current DAC sample index
// cfg_enable     in   1      allow new commands to be accepted
// cmd_valid      in   1      command handshake valid
// cmd_ready      out  1      command handshake ready
// cmd_time       in   56     burst start sample index
// cmd_len        in   LEN_W  number of payload words
// cmd_timed      in   1      1: wait until cmd_time; 0: send immediately
// s_valid        in   1      payload stream valid
// s_ready        out  1      payload stream ready
// s_data         in   64     payload sample word
// m_valid        out  1      tagged output stream valid
// m_ready        in   1      tagged output stream ready
// m_data         out  64     output word; HOLD tag: {8'd0, time}; SOB/EOB tags: 0
// m_tag_valid    out  1      m_data is a tag word
// m_tag_type     out  7      RWT_TAG_HOLD / RWT_TAG_SOB / RWT_TAG_EOB, from rwt_tag_types.vh
// busy           out  1      state != IDLE
// late_count     out  16     late commands seen; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: state=IDLE. cmd_ready, s_ready, m_valid, m_tag_valid, busy = 0. m_data, m_tag_type, late_count = 0.
// - Reset mid-burst abandons the burst immediately; no EOB is sent. The hold stage shares resetn.
// - States: IDLE, CHECK, HOLD, SOB, DATA, EOB, DRAIN.
// - IDLE: cmd_ready = cfg_enable. When cmd_valid && cmd_ready, latch time, len and timed.
//   Register diff = cmd_time - sample_idx (56-bit, wraps). Go to CHECK.
// - CHECK (1 cycle): late = timed && (diff[55] || diff < LATE_MARGIN).
//   On late, late_count increments (saturating).
//   late && DROP_LATE -> DRAIN. (timed && !late) -> HOLD. Otherwise -> SOB.
// - Latency: cmd accepted in cycle N gives the first m_valid in cycle N+2.
// - Output is registered. After m_valid rises, m_data, m_tag_valid and m_tag_type hold stable
//   until the cycle m_valid && m_ready.
// - HOLD / SOB / EOB each present one tag word. They advance on m_ready: HOLD->SOB, SOB->DATA,
//   and SOB->EOB when len==0. EOB returns to IDLE.
// - DATA: s_ready = m_ready || !m_valid (skid-free register slice). Each accepted s_data word goes out
//   with m_tag_valid=0 and decrements the remaining count. The last word is accepted -> EOB.
//   Input starvation inserts bubbles only and never an EOB.
// - DRAIN: s_ready=1, m_valid=0. Discards len words, then -> IDLE. len==0 gives immediate IDLE.
// - s_ready=0 in every state except DATA and DRAIN. cmd_ready=0 outside IDLE.
// - cfg_enable falling mid-burst does not abort; the burst completes and the block then stays in IDLE.
// - diff uses modular 56-bit arithmetic. A cmd_time exactly LATE_MARGIN ahead is on time.
//   Anything 2^55 or more ahead reads as late.
// TESTING
// 1 Untimed, len=3, m_ready=1, s_data 1,2,3 -> SOB, 1, 2, 3, EOB; first m_valid 2 cycles after the cmd handshake.
// 2 Timed, time=sample_idx+1000 -> HOLD word m_data=time, then SOB, payload, EOB; late_count stays 0.
// 3 Timed, time=sample_idx+10 (DROP_LATE=1), len=4 -> no m_valid; 4 payload words consumed; late_count=1.
// 4 Backpressure: m_ready toggles 1/0 every cycle in DATA -> all words in order, none lost,
//   m_data stable while stalled.
// 5 len=0 untimed -> SOB then EOB, s_ready never asserted.
// 6 resetn low in DATA after 2 of 8 words -> outputs at reset values next cycle; a new cmd starts from IDLE cleanly.

Source files
------------

// File: rtl/default_chan_block_tx_sched.sv
// Timed-burst TX sequencer: turns {time, len, timed} commands plus a raw sample stream into the
// HOLD / SOB / payload / EOB tagged stream consumed by the DAC hold stage.
module default_chan_block_tx_sched #(
    parameter int LEN_W       = 16,
    parameter int LATE_MARGIN = 64,
    parameter bit DROP_LATE   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [55:0]      sample_idx,
    input  logic             cfg_enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [55:0]      cmd_time,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_timed,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             m_tag_valid,
    output logic [6:0]       m_tag_type,
    output logic             busy,
    output logic [15:0]      late_count
);

    localparam logic [6:0] RWT_TAG_HOLD = 7'h01;
    localparam logic [6:0] RWT_TAG_SOB  = 7'h02;
    localparam logic [6:0] RWT_TAG_EOB  = 7'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HOLD,
        S_SOB,
        S_DATA,
        S_EOB,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [55:0]      time_q;
    logic [55:0]      diff_q;
    logic [LEN_W-1:0] rem_q;
    logic             timed_q;

    logic             late;
    logic             s_fire;
    logic             m_fire;
    logic             out_free;
    logic             rem_last;
    logic             rem_zero;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Modular lead time: negative (bit 55 set) or shorter than the margin is too late.
    function automatic logic is_late(input logic want_time, input logic [55:0] lead);
        return want_time && (lead[55] || (lead < 56'(LATE_MARGIN)));
    endfunction

    assign late      = is_late(timed_q, diff_q);
    assign cmd_ready = resetn && (state == S_IDLE) && cfg_enable;
    assign busy      = (state != S_IDLE);
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign out_free  = !m_valid || m_ready;
    assign rem_last  = (rem_q == LEN_W'(1));
    assign rem_zero  = (rem_q == '0);

    always_comb begin
        s_ready = 1'b0;
        if (resetn) begin
            case (state)
                S_DATA:  s_ready = out_free;
                S_DRAIN: s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            m_valid     <= 1'b0;
            m_tag_valid <= 1'b0;
            m_tag_type  <= 7'd0;
            m_data      <= 64'd0;
            late_count  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        time_q  <= cmd_time;
                        diff_q  <= cmd_time - sample_idx;
                        rem_q   <= cmd_len;
                        timed_q <= cmd_timed;
                        state   <= S_CHECK;
                    end
                end

                // The first tag is loaded here so it appears two cycles after the handshake.
                S_CHECK: begin
                    if (late) begin
                        late_count <= sat_inc16(late_count);
                    end
                    if (late && DROP_LATE) begin
                        state <= rem_zero ? S_IDLE : S_DRAIN;
                    end else if (timed_q && !late) begin
                        m_valid     <= 1'b1;
                        m_tag_valid <= 1'b1;
                        m_tag_type  <= RWT_TAG_HOLD;
                        m_data      <= {8'd0, time_q};
                        state       <= S_HOLD;
                    end else begin
                        m_valid     <= 1'b1;
                        m_tag_valid <= 1'b1;
                        m_tag_type  <= RWT_TAG_SOB;
                        m_data      <= 64'd0;
                        state       <= S_SOB;
                    end
                end

                S_HOLD: begin
                    if (m_ready) begin
                        m_tag_type <= RWT_TAG_SOB;
                        m_data     <= 64'd0;
                        state      <= S_SOB;
                    end
                end

                S_SOB: begin
                    if (m_ready) begin
                        if (rem_zero) begin
                            m_tag_type <= RWT_TAG_EOB;
                            m_data     <= 64'd0;
                            state      <= S_EOB;
                        end else begin
                            m_valid     <= 1'b0;
                            m_tag_valid <= 1'b0;
                            state       <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (s_fire) begin
                        m_valid     <= 1'b1;
                        m_tag_valid <= 1'b0;
                        m_tag_type  <= 7'd0;
                        m_data      <= s_data;
                        rem_q       <= rem_q - LEN_W'(1);
                        if (rem_last) begin
                            state <= S_EOB;
                        end
                    end else if (m_fire) begin
                        m_valid <= 1'b0;
                    end
                end

                // Entered with the last payload word possibly still in the output register.
                S_EOB: begin
                    if (m_tag_valid) begin
                        if (m_ready) begin
                            m_valid     <= 1'b0;
                            m_tag_valid <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else if (out_free) begin
                        m_valid     <= 1'b1;
                        m_tag_valid <= 1'b1;
                        m_tag_type  <= RWT_TAG_EOB;
                        m_data      <= 64'd0;
                    end
                end

                S_DRAIN: begin
                    if (s_fire) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_last) begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_default_chan_block_tx_sched.sv
// Bench for default_chan_block_tx_sched: vector table, randomized bursts against a
// word-list reference model, and a mid-burst reset sequence.
module tb_default_chan_block_tx_sched;

    localparam int LEN_W       = 16;
    localparam int LATE_MARGIN = 64;
    localparam bit DROP_LATE   = 1'b1;

    localparam logic [6:0] TAG_HOLD = 7'h01;
    localparam logic [6:0] TAG_SOB  = 7'h02;
    localparam logic [6:0] TAG_EOB  = 7'h03;

    logic             clk = 1'b0;
    logic             resetn;
    logic [55:0]      sample_idx;
    logic             cfg_enable;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [55:0]      cmd_time;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_timed;
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_data;
    logic             m_tag_valid;
    logic [6:0]       m_tag_type;
    logic             busy;
    logic [15:0]      late_count;

    always #5 clk = ~clk;

    default_chan_block_tx_sched #(
        .LEN_W(LEN_W),
        .LATE_MARGIN(LATE_MARGIN),
        .DROP_LATE(DROP_LATE)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .sample_idx(sample_idx),
        .cfg_enable(cfg_enable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_time(cmd_time),
        .cmd_len(cmd_len),
        .cmd_timed(cmd_timed),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_tag_valid(m_tag_valid),
        .m_tag_type(m_tag_type),
        .busy(busy),
        .late_count(late_count)
    );

    int errors = 0;
    int checks = 0;

    logic [71:0] exp_q[$];
    logic [63:0] src_q[$];

    typedef struct {
        string       nm;
        bit          timed;
        logic [55:0] delta;
        int          len;
        logic [55:0] sidx;
        int          mr;
        int          sv;
        bit          seq;
        bit          drop_en;
        bit          exp_late;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // A timed burst is on time when its lead lies in [LATE_MARGIN, 2^55).
    function automatic bit model_late(input bit timed, input logic [55:0] lead);
        if (!timed) return 1'b0;
        return !((lead >= 56'(LATE_MARGIN)) && (lead < (56'd1 << 55)));
    endfunction

    task automatic build_expected(input bit timed, input logic [55:0] t, input int len,
                                  input bit late, input bit seq);
        logic [63:0] w;
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            w = seq ? 64'(i + 1) : {$urandom, $urandom};
            src_q.push_back(w);
        end
        if (late && DROP_LATE) return;
        if (timed && !late) exp_q.push_back({1'b1, TAG_HOLD, 8'd0, t});
        exp_q.push_back({1'b1, TAG_SOB, 64'd0});
        for (int i = 0; i < src_q.size(); i++) exp_q.push_back({1'b0, 7'd0, src_q[i]});
        exp_q.push_back({1'b1, TAG_EOB, 64'd0});
    endtask

    task automatic check_reset(input string nm);
        chk({nm, " cmd_ready"}, 80'(cmd_ready), 80'(0));
        chk({nm, " s_ready"}, 80'(s_ready), 80'(0));
        chk({nm, " m_valid"}, 80'(m_valid), 80'(0));
        chk({nm, " m_tag_valid"}, 80'(m_tag_valid), 80'(0));
        chk({nm, " busy"}, 80'(busy), 80'(0));
        chk({nm, " m_data"}, 80'(m_data), 80'(0));
        chk({nm, " m_tag_type"}, 80'(m_tag_type), 80'(0));
        chk({nm, " late_count"}, 80'(late_count), 80'(0));
    endtask

    task automatic run_burst(input string nm, input bit timed, input logic [55:0] delta,
                             input int len, input logic [55:0] sidx, input int mr, input int sv,
                             input bit seq, input bit drop_en, input bit exp_late);
        logic [55:0] t;
        logic [15:0] lc0;
        logic [71:0] cur;
        logic [71:0] pword;
        bit          hs;
        bit          done;
        bit          seen;
        bit          pstall;
        int          cyc;
        int          hs_cyc;
        hs = 0; done = 0; seen = 0; pstall = 0; cyc = 0; hs_cyc = 0; pword = '0;
        t = sidx + delta;
        build_expected(timed, t, len, exp_late, seq);
        lc0        = late_count;
        sample_idx = sidx;
        cmd_time   = t;
        cmd_len    = 16'(len);
        cmd_timed  = timed;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cmd_valid  = !hs;
            cfg_enable = !(drop_en && hs);
            case (mr)
                0:       m_ready = 1'b1;
                1:       m_ready = cyc[0];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            s_valid = (sv == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            s_data  = (src_q.size() != 0) ? src_q[0] : (64'hDEAD_BEEF_0000_0000 | 64'(cyc));
            #1;
            cur = {m_tag_valid, (m_tag_valid ? m_tag_type : 7'd0), m_data};
            if (pstall) chk({nm, " stalled output"}, 80'({m_valid, cur}), 80'({1'b1, pword}));
            if (m_valid && !seen) begin
                seen = 1;
                chk({nm, " first m_valid latency"}, 80'(hs ? (cyc - hs_cyc) : -1), 80'(2));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) fail_now(nm, $sformatf("extra output word %0h", cur));
                else chk({nm, " output word"}, 80'(cur), 80'(exp_q.pop_front()));
            end
            if (s_valid && s_ready) begin
                if (src_q.size() == 0) fail_now(nm, "payload consumed beyond burst length");
                else void'(src_q.pop_front());
            end
            if (hs && !busy && exp_q.size() == 0 && src_q.size() == 0 && cyc > hs_cyc + 1) done = 1;
            if (cmd_valid && cmd_ready && !hs) begin
                hs     = 1;
                hs_cyc = cyc;
            end
            pstall = m_valid && !m_ready;
            pword  = cur;
            cyc++;
        end
        cmd_valid = 1'b0;
        if (!done) fail_now(nm, $sformatf("burst did not finish, busy=%0d pending=%0d", busy, exp_q.size()));
        chk({nm, " pending output words"}, 80'(exp_q.size()), 80'(0));
        chk({nm, " unconsumed payload"}, 80'(src_q.size()), 80'(0));
        chk({nm, " late_count"}, 80'(late_count), 80'(lc0) + 80'(exp_late));
        if (drop_en) begin
            cmd_valid = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #2;
                chk({nm, " stays idle while disabled"}, 80'({busy, cmd_ready}), 80'(0));
            end
            cmd_valid  = 1'b0;
            cfg_enable = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc;
        bit          hs;
        bit          rt;
        int          rlen;
        logic [55:0] rdelta;
        logic [55:0] rsidx;
        logic [63:0] tmp;

        vecs[0]  = '{"untimed_len3",    1'b0, 56'd0,                 3, 56'd100,  0, 0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"timed_ahead1000", 1'b1, 56'd1000,              4, 56'd5000, 0, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"timed_late10",    1'b1, 56'd10,                4, 56'd5000, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{"backpressure",    1'b0, 56'd0,                 8, 56'd42,   1, 0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"untimed_len0",    1'b0, 56'd0,                 0, 56'd9,    0, 0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"margin_exact",    1'b1, 56'd64,                2, 56'd300,  0, 0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"margin_minus1",   1'b1, 56'd63,                2, 56'd300,  0, 0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"ahead_2p55",      1'b1, 56'h80_0000_0000_0000, 2, 56'd77,   0, 0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"ahead_2p55m1",    1'b1, 56'h7F_FFFF_FFFF_FFFF, 2, 56'd77,   2, 1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"time_wraps",      1'b1, 56'd200,               3, 56'hFF_FFFF_FFFF_FFF0, 2, 1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"past_len0_drop",  1'b1, 56'hFF_FFFF_FFFF_FFFB, 0, 56'd1234, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"enable_drop",     1'b0, 56'd0,                 5, 56'd55,   2, 1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{"untimed_near",    1'b0, 56'd3,                 2, 56'd800,  0, 0, 1'b0, 1'b0, 1'b0};

        resetn     = 1'b0;
        cfg_enable = 1'b1;
        cmd_valid  = 1'b0;
        cmd_time   = '0;
        cmd_len    = '0;
        cmd_timed  = 1'b0;
        sample_idx = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_burst(vecs[i].nm, vecs[i].timed, vecs[i].delta, vecs[i].len, vecs[i].sidx,
                      vecs[i].mr, vecs[i].sv, vecs[i].seq, vecs[i].drop_en, vecs[i].exp_late);
        end

        for (int r = 0; r < 30; r++) begin
            rt  = 1'($urandom_range(0, 1));
            tmp = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rdelta = 56'($urandom_range(0, 150));
                1:       rdelta = tmp[55:0];
                2:       rdelta = 56'(LATE_MARGIN) - 56'd1 + 56'($urandom_range(0, 2));
                default: rdelta = (56'd1 << 55) - 56'd2 + 56'($urandom_range(0, 3));
            endcase
            tmp   = {$urandom, $urandom};
            rsidx = tmp[55:0];
            rlen  = $urandom_range(0, 10);
            run_burst($sformatf("rand%0d", r), rt, rdelta, rlen, rsidx, 2, 1, 1'b0, 1'b0,
                      model_late(rt, rdelta));
        end

        // Reset in the middle of a payload: after two of eight words have been taken.
        acc        = 0;
        hs         = 0;
        sample_idx = 56'd0;
        cmd_time   = 56'd0;
        cmd_len    = 16'd8;
        cmd_timed  = 1'b0;
        m_ready    = 1'b1;
        s_valid    = 1'b1;
        for (int k = 0; k < 50 && acc < 2; k++) begin
            @(posedge clk);
            #1;
            cmd_valid = !hs;
            s_data    = 64'(100 + acc);
            #1;
            if (cmd_valid && cmd_ready) hs = 1;
            if (s_valid && s_ready) acc++;
        end
        chk("midreset words before reset", 80'(acc), 80'(2));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        resetn    = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midreset");
        resetn  = 1'b1;
        s_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midreset no stray EOB", 80'({m_valid, busy}), 80'(0));
        end
        run_burst("after_reset", 1'b0, 56'd0, 3, 56'd777, 0, 0, 1'b1, 1'b0, 1'b0);
        run_burst("after_reset_timed", 1'b1, 56'd500, 2, 56'd777, 1, 0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
